// File: rtl/cpu_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// cpu_io_responder_pkg
//   Shared definitions for the CPU data/IO bus responder:
//   - vram_state_e : VRAM handshake FSM states
//   - io_off_e     : IO register word offsets (m_addr[3:2])
//   - io_read_word : IO read-back mux used by the responder
// ---------------------------------------------------------------------------
package cpu_io_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_RDONE = 2'd3
  } vram_state_e;

  typedef enum logic [1:0] {
    IO_SW   = 2'd0,
    IO_LED  = 2'd1,
    IO_STAT = 2'd2,
    IO_RSVD = 2'd3
  } io_off_e;

  // Read-back word for an IO load at the given offset.
  function automatic logic [31:0] io_read_word(
    input io_off_e     off,
    input logic [15:0] sw,
    input logic [15:0] led,
    input logic        fifo_full,
    input logic        fifo_empty
  );
    logic [31:0] word;
    word = '0;
    case (off)
      IO_SW:   word = {16'b0, sw};
      IO_LED:  word = {16'b0, led};
      IO_STAT: word = {30'b0, fifo_full, fifo_empty};
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cpu_io_responder_if.sv
// ---------------------------------------------------------------------------
// cpu_io_responder_if
//   Bundles the CPU-side data/IO bus and the VRAM-side request/ack bus.
//   slave  : the responder (receives CPU requests, issues VRAM requests)
//   master : the environment (CPU core + VRAM controller, or a testbench)
//   CPU side : m_addr, d_t_mem, write, io_rdn, io_wrn, rvram, wvram -> ;
//              <- d_f_mem, stall
//   VRAM side: <- vram_addr, vram_wdata, vram_we, vram_rd ;
//              vram_ack, vram_rdata ->
// ---------------------------------------------------------------------------
interface cpu_io_responder_if #(
  parameter int VRAM_AW = 12
);
  logic [31:0]        m_addr;
  logic [31:0]        d_t_mem;
  logic               write;
  logic               io_rdn;
  logic               io_wrn;
  logic               rvram;
  logic               wvram;
  logic [31:0]        d_f_mem;
  logic               stall;
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_wdata;
  logic               vram_we;
  logic               vram_rd;
  logic               vram_ack;
  logic [31:0]        vram_rdata;

  modport slave (
    input  m_addr, d_t_mem, write, io_rdn, io_wrn, rvram, wvram,
    input  vram_ack, vram_rdata,
    output d_f_mem, stall,
    output vram_addr, vram_wdata, vram_we, vram_rd
  );

  modport master (
    output m_addr, d_t_mem, write, io_rdn, io_wrn, rvram, wvram,
    output vram_ack, vram_rdata,
    input  d_f_mem, stall,
    input  vram_addr, vram_wdata, vram_we, vram_rd
  );
endinterface

// File: rtl/cpu_io_responder_vram_wr_fifo.sv
// ---------------------------------------------------------------------------
// vram_wr_fifo
//   Small synchronous FIFO buffering CPU VRAM writes toward the slower
//   display side. Head data is combinational (show-ahead).
//   Ports:
//     clk, clrn   clock / async active-low reset (pointers only)
//     push        enqueue push_data (ignored when full)
//     push_data   entry to enqueue
//     pop         dequeue head (ignored when empty)
//     head        current head entry
//     full, empty occupancy flags
//   Pointers carry one extra wrap bit: equal pointers mean empty, pointers
//   differing only in the wrap bit mean full. They wrap silently.
// ---------------------------------------------------------------------------
module vram_wr_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a value first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    head     = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries
  // are valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_io_responder.sv
// ---------------------------------------------------------------------------
// cpu_io_responder
//   Target side of the single-cycle CPU data/IO bus. Serves loads from data
//   RAM, IO registers or VRAM; queues VRAM writes in a FIFO drained by a
//   request/ack handshake FSM; raises stall while a VRAM read is pending or
//   a VRAM write meets a full FIFO.
//   Ports:
//     clk, clrn  clock / async active-low reset
//     bus        cpu_io_responder_if.slave (CPU bus + VRAM bus)
//     sw         switch inputs (IO offset 0 read)
//     led        LED register (IO offset 0 write, offset 1 read)
// ---------------------------------------------------------------------------
module cpu_io_responder
  import cpu_io_responder_pkg::*;
#(
  parameter int DMEM_AW    = 8,
  parameter int VRAM_AW    = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clrn,
  cpu_io_responder_if.slave bus,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);
  localparam int FW = VRAM_AW + 32;

  vram_state_e        state_q, state_d;
  logic [15:0]        led_q, led_d;
  logic [31:0]        rd_buf_q, rd_buf_d;

  logic [31:0]        dmem [2**DMEM_AW];
  logic [DMEM_AW-1:0] dmem_idx;
  logic [VRAM_AW-1:0] cpu_vram_idx;
  io_off_e            io_off;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]      fifo_head;

  logic               stall;
  logic               io_we, ram_we;
  logic               vram_we, vram_rd;
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_wdata;
  logic [31:0]        d_f_mem;

  assign dmem_idx     = bus.m_addr[DMEM_AW+1:2];
  assign cpu_vram_idx = bus.m_addr[VRAM_AW+1:2];
  assign io_off       = io_off_e'(bus.m_addr[3:2]);

  vram_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (fifo_push),
    .push_data ({cpu_vram_idx, bus.d_t_mem}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Full is sampled before any pop this cycle, so a write that meets a full
  // FIFO stays stalled through the pop cycle and is accepted one cycle later.
  // Gating with clrn releases the CPU the moment reset asserts.
  always_comb begin
    stall = clrn & ((bus.wvram & fifo_full) |
                    (bus.rvram & (state_q != S_RDONE)));
  end

  // Store decode: wvram beats an IO write, which beats a RAM write.
  // The LED register is written through offset 0 (the switch offset,
  // which is read-only).
  always_comb begin
    fifo_push = bus.wvram & ~fifo_full;
    io_we     = ~bus.wvram & ~bus.io_wrn & ~stall;
    ram_we    = ~bus.wvram & bus.io_wrn & bus.write & ~stall;
    led_d     = led_q;
    if (io_we && io_off == IO_SW) begin
      led_d = bus.d_t_mem[15:0];
    end
  end

  // Load mux: VRAM read buffer beats IO, which beats RAM.
  always_comb begin
    if (bus.rvram) begin
      d_f_mem = rd_buf_q;
    end else if (!bus.io_rdn) begin
      d_f_mem = io_read_word(io_off, sw, led_q, fifo_full, fifo_empty);
    end else begin
      d_f_mem = dmem[dmem_idx];
    end
  end

  // VRAM handshake FSM. Pending writes always drain before a read starts,
  // so a read never overtakes a queued write to the same location.
  always_comb begin
    state_d    = state_q;
    rd_buf_d   = rd_buf_q;
    fifo_pop   = 1'b0;
    vram_we    = 1'b0;
    vram_rd    = 1'b0;
    vram_addr  = fifo_head[FW-1:32];
    vram_wdata = fifo_head[31:0];
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_WR;
        end else if (bus.rvram) begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        vram_we = 1'b1;
        if (bus.vram_ack) begin
          fifo_pop = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RD: begin
        vram_rd   = 1'b1;
        vram_addr = cpu_vram_idx;
        if (bus.vram_ack) begin
          rd_buf_d = bus.vram_rdata;
          state_d  = S_RDONE;
        end
      end
      S_RDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      dmem[dmem_idx] <= bus.d_t_mem;
    end
  end

  assign bus.d_f_mem    = d_f_mem;
  assign bus.stall      = stall;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_wdata = vram_wdata;
  assign bus.vram_we    = vram_we;
  assign bus.vram_rd    = vram_rd;
  assign led            = led_q;

endmodule

// File: tb/tb_cpu_io_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_responder
//   Directed stimulus for cpu_io_responder. A transaction-level model (queue
//   of pending VRAM writes, LED value, sparse RAM image) is updated on each
//   falling edge for the upcoming rising edge and compared against the DUT
//   every cycle; directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_cpu_io_responder;
  localparam int DMEM_AW    = 8;
  localparam int VRAM_AW    = 12;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [VRAM_AW-1:0] addr;
    logic [31:0]        data;
  } vw_t;

  logic        clk  = 1'b0;
  logic        clrn = 1'b0;
  logic [15:0] sw;
  logic [15:0] led;

  cpu_io_responder_if #(.VRAM_AW(VRAM_AW)) bus();

  cpu_io_responder #(
    .DMEM_AW    (DMEM_AW),
    .VRAM_AW    (VRAM_AW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus),
    .sw   (sw),
    .led  (led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  vw_t         m_q[$];
  logic [15:0] m_led     = '0;
  logic [31:0] m_dmem [int];
  logic [31:0] m_rd_data = '0;
  bit          m_full, m_empty;
  vw_t         m_head;
  int          m_idx;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] io_expect(input logic [1:0] off,
                                            input logic [15:0] s,
                                            input logic [15:0] l,
                                            input bit full, input bit empty);
    if (off == 2'd0) return {16'h0, s};
    if (off == 2'd1) return {16'h0, l};
    if (off == 2'd2) return {30'h0, full, empty};
    return 32'h0;
  endfunction

  // Per-cycle comparison against the model, then model update for the edge.
  always @(negedge clk) begin
    if (!clrn) begin
      m_q.delete();
      m_led = '0;
    end else begin
      m_full  = (m_q.size() == FIFO_DEPTH);
      m_empty = (m_q.size() == 0);
      m_idx   = int'(bus.m_addr[DMEM_AW+1:2]);
      check("led", 32'(led), 32'(m_led));
      check("we_rd_exclusive", 32'(bus.vram_we & bus.vram_rd), 32'h0);
      if (!bus.rvram) begin
        check("stall", 32'(bus.stall), 32'(bus.wvram && m_full));
        if (!bus.io_rdn)
          check("io_read", bus.d_f_mem,
                io_expect(bus.m_addr[3:2], sw, m_led, m_full, m_empty));
        else if (m_dmem.exists(m_idx))
          check("ram_read", bus.d_f_mem, m_dmem[m_idx]);
      end else if (!bus.stall) begin
        check("vram_read_data", bus.d_f_mem, m_rd_data);
      end
      // VRAM side: completed writes must match the oldest pending write.
      if (bus.vram_we && bus.vram_ack) begin
        check("write_pending", 32'(m_q.size() > 0), 32'h1);
        if (m_q.size() > 0) begin
          m_head = m_q.pop_front();
          check("vram_wr_addr", 32'(bus.vram_addr), 32'(m_head.addr));
          check("vram_wr_data", bus.vram_wdata, m_head.data);
        end
      end
      if (bus.vram_rd && bus.vram_ack) begin
        check("read_after_drain", m_q.size(), 0);
        check("vram_rd_addr", 32'(bus.vram_addr), 32'(bus.m_addr[VRAM_AW+1:2]));
        m_rd_data = bus.vram_rdata;
      end
      // Stores taking effect at the coming edge.
      if (bus.wvram) begin
        if (!m_full) m_q.push_back('{addr: bus.m_addr[VRAM_AW+1:2], data: bus.d_t_mem});
      end else if (!bus.io_wrn) begin
        if (!bus.rvram && bus.m_addr[3:2] == 2'd0) m_led = bus.d_t_mem[15:0];
      end else if (bus.write && !bus.rvram) begin
        m_dmem[m_idx] = bus.d_t_mem;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_addr  = '0;
    bus.d_t_mem = '0;
    bus.write   = 1'b0;
    bus.io_rdn  = 1'b1;
    bus.io_wrn  = 1'b1;
    bus.rvram   = 1'b0;
    bus.wvram   = 1'b0;
  endtask

  // Wait (bounded) for a VRAM request, then ack it for one cycle.
  task automatic serve(input logic [31:0] rdata, output logic was_rd,
                       output logic [31:0] addr);
    int waited = 0;
    was_rd = 1'b0;
    addr   = '0;
    while (!(bus.vram_we || bus.vram_rd) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL vram_request_timeout: got no request, expected one within 50 cycles");
    end else begin
      was_rd = bus.vram_rd;
      addr   = 32'(bus.vram_addr);
      @(posedge clk);
      #1;
      bus.vram_rdata = rdata;
      bus.vram_ack   = 1'b1;
      cyc();
      bus.vram_ack   = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        was_rd;
    logic [31:0] saddr;
    int          stall_cycles;
    logic [31:0] addrs [4];
    logic        kinds [3];

    idle_inputs();
    sw             = 16'h0;
    bus.vram_ack   = 1'b0;
    bus.vram_rdata = '0;
    clrn           = 1'b0;
    #12;
    check("rst_led", 32'(led), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_vram_we", 32'(bus.vram_we), 32'h0);
    check("rst_vram_rd", 32'(bus.vram_rd), 32'h0);
    cyc();
    clrn = 1'b1;
    bus.io_rdn = 1'b0; bus.m_addr = 32'h8;
    @(negedge clk); check("rst_status", bus.d_f_mem, 32'h1);
    cyc(); idle_inputs();

    // 1: RAM store then load
    bus.write = 1'b1; bus.m_addr = 32'h10; bus.d_t_mem = 32'hDEADBEEF;
    cyc(); bus.write = 1'b0;
    @(negedge clk);
    check("ram_load", bus.d_f_mem, 32'hDEADBEEF);
    check("ram_stall", 32'(bus.stall), 32'h0);
    cyc();

    // 2: IO registers
    bus.io_wrn = 1'b0; bus.m_addr = 32'h0; bus.d_t_mem = 32'h1234;
    cyc(); bus.io_wrn = 1'b1;
    @(negedge clk); check("led_write", 32'(led), 32'h1234);
    cyc();
    bus.io_wrn = 1'b0; bus.m_addr = 32'h4; bus.d_t_mem = 32'hFFFF;
    cyc(); bus.io_wrn = 1'b1;
    @(negedge clk); check("led_offset1_ignored", 32'(led), 32'h1234);
    cyc();
    sw = 16'hA5A5; bus.io_rdn = 1'b0; bus.m_addr = 32'h0;
    @(negedge clk); check("io_sw", bus.d_f_mem, 32'h0000A5A5);
    cyc(); bus.m_addr = 32'h4;
    @(negedge clk); check("io_led", bus.d_f_mem, 32'h00001234);
    cyc(); bus.m_addr = 32'h8;
    @(negedge clk); check("io_status", bus.d_f_mem, 32'h1);
    cyc(); bus.m_addr = 32'hC;
    @(negedge clk); check("io_reserved", bus.d_f_mem, 32'h0);
    cyc(); idle_inputs();
    // Priority: IO write beats RAM write; wvram beats IO write.
    bus.write = 1'b1; bus.m_addr = 32'h0; bus.d_t_mem = 32'h11111111;
    cyc();
    bus.io_wrn = 1'b0; bus.d_t_mem = 32'h00005555;
    cyc(); idle_inputs();
    @(negedge clk);
    check("prio_io_led", 32'(led), 32'h5555);
    check("prio_ram_kept", bus.d_f_mem, 32'h11111111);
    cyc();
    bus.wvram = 1'b1; bus.io_wrn = 1'b0; bus.d_t_mem = 32'h7777;
    cyc(); idle_inputs();
    @(negedge clk); check("prio_vram_led_kept", 32'(led), 32'h5555);
    cyc();
    serve(32'h0, was_rd, saddr);
    check("prio_vram_is_write", 32'(was_rd), 32'h0);
    check("prio_vram_addr", saddr, 32'h0);

    // 3: FIFO full with ack held low
    for (int i = 0; i < 5; i++) begin
      bus.wvram = 1'b1; bus.m_addr = 32'h100 + 32'(4 * i); bus.d_t_mem = 32'hA0000000 + 32'(i);
      @(negedge clk);
      check($sformatf("fifo_push_%0d_stall", i), 32'(bus.stall), (i < 4) ? 32'h0 : 32'h1);
      cyc();
    end
    bus.vram_ack = 1'b1;
    @(negedge clk);
    check("full_during_pop_stall", 32'(bus.stall), 32'h1);
    check("full_head_addr", 32'(bus.vram_addr), 32'h40);
    cyc(); bus.vram_ack = 1'b0;
    @(negedge clk); check("fifth_accepted", 32'(bus.stall), 32'h0);
    cyc(); idle_inputs();
    for (int i = 0; i < 4; i++) serve(32'h0, was_rd, addrs[i]);
    for (int i = 0; i < 4; i++) check($sformatf("issue_order_%0d", i), addrs[i], 32'h41 + 32'(i));

    // 4: read after queued writes to the same address
    bus.wvram = 1'b1; bus.m_addr = 32'h300; bus.d_t_mem = 32'h1111;
    cyc(); bus.d_t_mem = 32'h2222;
    cyc(); idle_inputs();
    bus.rvram = 1'b1; bus.m_addr = 32'h300;
    for (int i = 0; i < 3; i++) serve(32'h22220BAD, kinds[i], saddr);
    check("order_wr0", 32'(kinds[0]), 32'h0);
    check("order_wr1", 32'(kinds[1]), 32'h0);
    check("order_rd", 32'(kinds[2]), 32'h1);
    @(negedge clk);
    check("rdone_stall", 32'(bus.stall), 32'h0);
    check("rdone_data", bus.d_f_mem, 32'h22220BAD);
    cyc(); idle_inputs();
    cyc();

    // 5: minimum read latency
    stall_cycles = 0;
    bus.rvram = 1'b1; bus.m_addr = 32'h200;
    @(negedge clk); stall_cycles += int'(bus.stall);
    check("lat_rd_not_yet", 32'(bus.vram_rd), 32'h0);
    cyc();
    bus.vram_ack = 1'b1; bus.vram_rdata = 32'hCAFEF00D;
    @(negedge clk); stall_cycles += int'(bus.stall);
    check("lat_rd_high", 32'(bus.vram_rd), 32'h1);
    cyc(); bus.vram_ack = 1'b0;
    @(negedge clk); stall_cycles += int'(bus.stall);
    check("lat_data", bus.d_f_mem, 32'hCAFEF00D);
    check("lat_stall_cycles", 32'(stall_cycles), 32'h2);
    cyc(); idle_inputs();

    // Stray ack while idle is ignored
    bus.vram_ack = 1'b1;
    cyc(); bus.vram_ack = 1'b0; bus.io_rdn = 1'b0; bus.m_addr = 32'h8;
    @(negedge clk);
    check("stray_ack_status", bus.d_f_mem, 32'h1);
    check("stray_ack_no_we", 32'(bus.vram_we), 32'h0);
    cyc(); idle_inputs();

    // 6a: reset discards queued writes
    bus.wvram = 1'b1; bus.m_addr = 32'h500; bus.d_t_mem = 32'h5;
    cyc(); bus.m_addr = 32'h504;
    cyc(); idle_inputs();
    check("pre_reset_we", 32'(bus.vram_we), 32'h1);
    #2; clrn = 1'b0;
    #1; check("reset_we_drop", 32'(bus.vram_we), 32'h0);
    cyc(); clrn = 1'b1; bus.io_rdn = 1'b0; bus.m_addr = 32'h8;
    @(negedge clk);
    check("fifo_discarded", bus.d_f_mem, 32'h1);
    check("post_reset_no_we", 32'(bus.vram_we), 32'h0);
    cyc(); idle_inputs();

    // 6b: reset mid-read
    bus.io_wrn = 1'b0; bus.m_addr = 32'h0; bus.d_t_mem = 32'hBEEF;
    cyc(); idle_inputs();
    bus.rvram = 1'b1; bus.m_addr = 32'h600;
    cyc();
    check("pre_reset_rd", 32'(bus.vram_rd), 32'h1);
    #2; clrn = 1'b0;
    #1;
    check("reset_rd_drop", 32'(bus.vram_rd), 32'h0);
    check("reset_stall_drop", 32'(bus.stall), 32'h0);
    idle_inputs();
    cyc(); clrn = 1'b1; bus.io_rdn = 1'b0; bus.m_addr = 32'h8;
    @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_status", bus.d_f_mem, 32'h1);
    cyc(); idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
